// File: rtl/multi_player_arbiter_game_pkg.sv
// Shared types and constants for the N-player reaction game.
package arbiter_game_pkg;
  typedef enum logic [2:0] {IDLE, COUNTDOWN, ARMED, WIN_SHOW, FOUL_SHOW} state_e;

  localparam int SCORE_W = 4;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/multi_player_arbiter_game_if.sv
// Pin-side bundle of the reaction game: buttons in, display and result out.
interface multi_player_arbiter_game_if #(
  parameter int N_PLAYERS = 4,
  parameter int CD_STEPS  = 4
);
  import arbiter_game_pkg::*;
  localparam int ID_W = id_w(N_PLAYERS);

  logic [N_PLAYERS-1:0] req_n_in;
  logic [CD_STEPS-1:0]  cd_leds_out;
  logic [N_PLAYERS-1:0] leds_out;
  logic [ID_W-1:0]      winner_id_out;
  logic                 winner_valid_out;
  logic                 foul_out;
`ifdef ARBITER_GAME_SCORE_EN
  logic [N_PLAYERS*SCORE_W-1:0] score_out;
`endif

  modport master (
    output req_n_in,
    input  cd_leds_out, leds_out, winner_id_out, winner_valid_out, foul_out
`ifdef ARBITER_GAME_SCORE_EN
    , input score_out
`endif
  );

  modport slave (
    input  req_n_in,
    output cd_leds_out, leds_out, winner_id_out, winner_valid_out, foul_out
`ifdef ARBITER_GAME_SCORE_EN
    , output score_out
`endif
  );
endinterface

// File: rtl/multi_player_arbiter_game_tick_prescaler.sv
// Game tick generator: one-cycle pulse every PRESCALER_COUNT clocks, restartable.
module tick_prescaler #(
  parameter int PRESCALER_COUNT = 250
) (
  input  logic clk,
  input  logic rst_in_n,
  input  logic restart,
  output logic tick
);
  localparam int CW = (PRESCALER_COUNT > 1) ? $clog2(PRESCALER_COUNT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == CW'(PRESCALER_COUNT - 1));
  assign cnt_d = (restart || tick) ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk) begin
    if (!rst_in_n) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end
endmodule

// File: rtl/multi_player_arbiter_game.sv
// N-player reaction game: countdown, armed race with round-robin tie-break, foul/timeout.
// Optional per-player score counters when ARBITER_GAME_SCORE_EN is defined.
module multi_player_arbiter_game
  import arbiter_game_pkg::*;
#(
  parameter int N_PLAYERS       = 4,
  parameter int CLOCK_FREQ      = 1000,
  parameter int PRESCALER_COUNT = CLOCK_FREQ / 4,
  parameter int CD_STEPS        = 4,
  parameter int WIN_TICKS       = 8,
  parameter int TIMEOUT_TICKS   = 16
) (
  input logic clk,
  input logic rst_in_n,
  multi_player_arbiter_game_if.slave bus
);
  localparam int ID_W  = id_w(N_PLAYERS);
  localparam int MAX_T = (CD_STEPS > WIN_TICKS)
                       ? ((CD_STEPS > TIMEOUT_TICKS) ? CD_STEPS : TIMEOUT_TICKS)
                       : ((WIN_TICKS > TIMEOUT_TICKS) ? WIN_TICKS : TIMEOUT_TICKS);
  localparam int TW    = $clog2(MAX_T + 1);

  state_e               state_q, state_d;
  logic [N_PLAYERS-1:0] sync1_q, sync2_q, req, elig, rot, gnt_oh, win_oh;
  logic [N_PLAYERS-1:0] foul_q, foul_d, foul_nx, leds_q, leds_d;
  logic [CD_STEPS-1:0]  cd_q, cd_d;
  logic [ID_W-1:0]      id_q, id_d, rr_q, rr_d, rot_k, gnt_idx;
  logic [ID_W:0]        gnt_sum, rr_inc;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic                 gnt_vld, tick, restart;

  tick_prescaler #(.PRESCALER_COUNT(PRESCALER_COUNT)) u_tick (
    .clk(clk), .rst_in_n(rst_in_n), .restart(restart), .tick(tick)
  );

  assign req     = ~sync2_q;
  assign foul_nx = foul_q | req;
  assign elig    = req & ~foul_q;

  // Rotate so the RR pointer sits at bit 0, pick the lowest set bit, rotate back.
  assign rot = (elig >> rr_q) | (elig << (N_PLAYERS - int'(rr_q)));
  always_comb begin
    gnt_vld = |rot;
    rot_k   = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--)
      if (rot[i]) rot_k = ID_W'(i);
  end
  assign gnt_sum = {1'b0, rr_q} + {1'b0, rot_k};
  assign gnt_idx = (gnt_sum >= (ID_W+1)'(N_PLAYERS)) ? gnt_sum[ID_W-1:0] - ID_W'(N_PLAYERS)
                                                     : gnt_sum[ID_W-1:0];
  assign gnt_oh  = N_PLAYERS'(1) << gnt_idx;
  assign win_oh  = N_PLAYERS'(1) << id_q;
  assign rr_inc  = {1'b0, id_q} + (ID_W+1)'(1);

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    leds_d  = leds_q;
    id_d    = id_q;
    rr_d    = rr_q;
    foul_d  = foul_q;
    tcnt_d  = tick ? tcnt_q + TW'(1) : tcnt_q;
    case (state_q)
      IDLE: if (!(|req) && tick) begin
        state_d = COUNTDOWN;
        cd_d    = '1;
        foul_d  = '0;
      end
      COUNTDOWN: begin
        foul_d = foul_nx;
        if (tick) begin
          cd_d = cd_q >> 1;
          if (tcnt_q == TW'(CD_STEPS - 1)) begin
            if (&foul_nx) begin
              state_d = FOUL_SHOW;
              leds_d  = foul_nx;
            end else begin
              state_d = ARMED;
            end
          end
        end
      end
      ARMED: begin
        if (gnt_vld) begin
          state_d = WIN_SHOW;
          id_d    = gnt_idx;
          leds_d  = gnt_oh;
        end else if (tick && tcnt_q == TW'(TIMEOUT_TICKS - 1)) begin
          state_d = IDLE;
        end
      end
      WIN_SHOW: if (tick) begin
        if (tcnt_q == TW'(WIN_TICKS - 1)) begin
          state_d = IDLE;
          leds_d  = '0;
          rr_d    = (rr_inc == (ID_W+1)'(N_PLAYERS)) ? '0 : rr_inc[ID_W-1:0];
        end else begin
          leds_d  = leds_q ^ win_oh;
        end
      end
      FOUL_SHOW: if (tick && tcnt_q == TW'(WIN_TICKS - 1)) begin
        state_d = IDLE;
        leds_d  = '0;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) tcnt_d = '0;
  end

  assign restart = (state_d != state_q);

  always_ff @(posedge clk) begin
    if (!rst_in_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_in_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      cd_q    <= '0;
      leds_q  <= '0;
      id_q    <= '0;
      rr_q    <= '0;
      foul_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      sync1_q <= bus.req_n_in;
      sync2_q <= sync1_q;
      cd_q    <= cd_d;
      leds_q  <= leds_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
      foul_q  <= foul_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign bus.cd_leds_out      = cd_q;
  assign bus.leds_out         = leds_q;
  assign bus.winner_id_out    = id_q;
  assign bus.winner_valid_out = (state_q == WIN_SHOW);
  assign bus.foul_out         = (state_q == FOUL_SHOW);

`ifdef ARBITER_GAME_SCORE_EN
  logic [N_PLAYERS-1:0][SCORE_W-1:0] score_q, score_d;

  // Win credit lands on WIN_SHOW entry, foul penalty on COUNTDOWN exit; both saturate.
  always_comb begin
    score_d = score_q;
    for (int p = 0; p < N_PLAYERS; p++) begin
      if (state_q == ARMED && state_d == WIN_SHOW && gnt_oh[p] && score_q[p] != '1)
        score_d[p] = score_q[p] + SCORE_W'(1);
      if (state_q == COUNTDOWN && state_d != COUNTDOWN && foul_nx[p] && score_q[p] != '0)
        score_d[p] = score_q[p] - SCORE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_in_n) score_q <= '0;
    else           score_q <= score_d;
  end

  assign bus.score_out = score_q;
`endif
endmodule
